// File: rtl/feistel_round_engine_if.sv
// ---------------------------------------------------------------------------
// feistel_round_engine_if
//
// Purpose:
//   Bundles the handshake, data, round-key and S-box lane signals of the
//   Feistel round engine so the controller/ROM side and the engine can be
//   connected with a single port.
//
// Parameters:
//   WORD_W  width of one state word (state is 4*WORD_W bits)
//   RND_W   width of the round index
//
// Signals (direction given from the engine's point of view, modport slave):
//   start        in   begin a block (honoured only when the engine is idle/done)
//   mode         in   0 = encrypt, 1 = decrypt (only with FEISTEL_DECRYPT_EN)
//   din          in   input block, word3 in the top WORD_W bits
//   dout         out  state register, holds the result once done pulses
//   busy         out  high while rounds are being computed
//   done         out  one-cycle pulse when the result is ready
//   round_idx    out  round whose keys / S-box table are needed this cycle
//   sbox_sel     out  S-box table select (round_idx[0])
//   key1..key3   in   round keys for round_idx
//   sbox_in_1..3 out  S-box lane inputs
//   sbox_out_1..3 in  S-box lane outputs (same-cycle combinational)
//
// Modports:
//   master  controller / key-schedule / S-box side
//   slave   the round engine
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

interface feistel_round_engine_if #(
    parameter int WORD_W = 9,
    parameter int RND_W  = 8
);
    logic                  start;
    logic                  mode;
    logic [4*WORD_W-1:0]   din;
    logic [4*WORD_W-1:0]   dout;
    logic                  busy;
    logic                  done;
    logic [RND_W-1:0]      round_idx;
    logic                  sbox_sel;
    logic [WORD_W-1:0]     key1;
    logic [WORD_W-1:0]     key2;
    logic [WORD_W-1:0]     key3;
    logic [WORD_W-1:0]     sbox_in_1;
    logic [WORD_W-1:0]     sbox_in_2;
    logic [WORD_W-1:0]     sbox_in_3;
    logic [WORD_W-1:0]     sbox_out_1;
    logic [WORD_W-1:0]     sbox_out_2;
    logic [WORD_W-1:0]     sbox_out_3;

    modport master (
        output start, mode, din,
        output key1, key2, key3,
        output sbox_out_1, sbox_out_2, sbox_out_3,
        input  dout, busy, done, round_idx, sbox_sel,
        input  sbox_in_1, sbox_in_2, sbox_in_3
    );

    modport slave (
        input  start, mode, din,
        input  key1, key2, key3,
        input  sbox_out_1, sbox_out_2, sbox_out_3,
        output dout, busy, done, round_idx, sbox_sel,
        output sbox_in_1, sbox_in_2, sbox_in_3
    );
endinterface

// File: rtl/feistel_round_engine.sv
// ---------------------------------------------------------------------------
// feistel_round_engine
//
// Purpose:
//   Iterative 4-word Feistel-style round engine. The state (word3..word0)
//   is updated one encrypt round per clock using round keys and S-box
//   results supplied combinationally by external key-schedule and S-box
//   ROM blocks. A start/busy/done handshake frames each block.
//
// Optional feature (macro FEISTEL_DECRYPT_EN):
//   When defined, mode=1 runs the inverse rounds. Each inverse round takes
//   three cycles (phases 0..2) because the three S-box lanes depend on each
//   other in reverse order; round_idx counts down from NUM_ROUNDS-1 to 0.
//   When undefined, the mode input is ignored and the engine always
//   encrypts; no phase counter or temporaries are built.
//
// Parameters:
//   WORD_W      width of each state word
//   NUM_ROUNDS  rounds per block (>= 1)
//   RND_W       width of round_idx (2**RND_W > NUM_ROUNDS-1)
//
// Ports:
//   clk    clock, all logic on the rising edge
//   rst_n  synchronous active-low reset
//   bus    feistel_round_engine_if.slave (handshake, data, keys, S-box lanes)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module feistel_round_engine #(
    parameter int WORD_W     = 9,
    parameter int NUM_ROUNDS = 31,
    parameter int RND_W      = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    feistel_round_engine_if.slave   bus
);

    localparam logic [RND_W-1:0] LAST_IDX = RND_W'(NUM_ROUNDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [3:0][WORD_W-1:0]    s_q, s_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic [RND_W-1:0]          round_idx_q, round_idx_d;

    logic [WORD_W-1:0]         sbox_in_1, sbox_in_2, sbox_in_3;
    logic [3:0][WORD_W-1:0]    enc_next;

`ifdef FEISTEL_DECRYPT_EN
    logic                      mode_q, mode_d;
    logic [1:0]                phase_q, phase_d;
    logic [WORD_W-1:0]         n2_q, n2_d;
    logic [WORD_W-1:0]         n1_q, n1_d;
`else
    // Encrypt-only build: mode is accepted on the bus but has no effect.
    logic                      unused_mode;
    assign unused_mode = bus.mode;
`endif

    // One forward round. Lane k of the S-box sees word k of the state, and
    // the old word3 rotates down into word0.
    assign enc_next = {bus.key1 ^ s_q[2] ^ bus.sbox_out_3,
                       bus.key2 ^ s_q[1] ^ bus.sbox_out_2,
                       bus.key3 ^ s_q[0] ^ bus.sbox_out_1,
                       s_q[3]};

    // S-box lane routing. Lanes default to the forward mapping; during an
    // inverse round only the lane needed by the current phase is rerouted,
    // so the external S-box always sees a well-defined input.
    always_comb begin
        sbox_in_3 = s_q[3];
        sbox_in_2 = s_q[2];
        sbox_in_1 = s_q[1];
`ifdef FEISTEL_DECRYPT_EN
        if ((state_q == ST_RUN) && mode_q) begin
            case (phase_q)
                2'd0:    sbox_in_3 = s_q[0];
                2'd1:    sbox_in_2 = n2_q;
                2'd2:    sbox_in_1 = n1_q;
                default: ;
            endcase
        end
`endif
    end

    // Next-state logic for the control FSM and the datapath registers.
    // A new block is accepted in IDLE and also in the DONE cycle so blocks
    // can be streamed back to back; start is never looked at during RUN.
    // Keys and S-box outputs only influence the state while in RUN.
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        busy_d      = busy_q;
        done_d      = done_q;
        round_idx_d = round_idx_q;
`ifdef FEISTEL_DECRYPT_EN
        mode_d      = mode_q;
        phase_d     = phase_q;
        n2_d        = n2_q;
        n1_d        = n1_q;
`endif

        case (state_q)
            ST_IDLE, ST_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (bus.start) begin
                    state_d     = ST_RUN;
                    s_d         = bus.din;
                    busy_d      = 1'b1;
                    round_idx_d = '0;
`ifdef FEISTEL_DECRYPT_EN
                    mode_d      = bus.mode;
                    phase_d     = 2'd0;
                    if (bus.mode) begin
                        round_idx_d = LAST_IDX;
                    end
`endif
                end
            end

            ST_RUN: begin
`ifdef FEISTEL_DECRYPT_EN
                if (mode_q) begin
                    // Inverse round: recover old word2, then old word1, and
                    // finally old word0 while rotating the words back up.
                    case (phase_q)
                        2'd0: begin
                            n2_d    = s_q[3] ^ bus.key1 ^ bus.sbox_out_3;
                            phase_d = 2'd1;
                        end
                        2'd1: begin
                            n1_d    = s_q[2] ^ bus.key2 ^ bus.sbox_out_2;
                            phase_d = 2'd2;
                        end
                        2'd2: begin
                            s_d     = {s_q[0], n2_q, n1_q,
                                       s_q[1] ^ bus.key3 ^ bus.sbox_out_1};
                            phase_d = 2'd0;
                            if (round_idx_q == '0) begin
                                state_d = ST_DONE;
                                busy_d  = 1'b0;
                                done_d  = 1'b1;
                            end else begin
                                round_idx_d = round_idx_q - RND_W'(1);
                            end
                        end
                        default: begin
                            phase_d = 2'd0;
                        end
                    endcase
                end else begin
                    s_d = enc_next;
                    if (round_idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        round_idx_d = round_idx_q + RND_W'(1);
                    end
                end
`else
                s_d = enc_next;
                if (round_idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    round_idx_d = round_idx_q + RND_W'(1);
                end
`endif
            end

            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State registers. Reset is synchronous and wins over any block in
    // flight, so an interrupted block never produces a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            s_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            round_idx_q <= '0;
`ifdef FEISTEL_DECRYPT_EN
            mode_q      <= 1'b0;
            phase_q     <= 2'd0;
            n2_q        <= '0;
            n1_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            round_idx_q <= round_idx_d;
`ifdef FEISTEL_DECRYPT_EN
            mode_q      <= mode_d;
            phase_q     <= phase_d;
            n2_q        <= n2_d;
            n1_q        <= n1_d;
`endif
        end
    end

    assign bus.dout      = s_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.round_idx = round_idx_q;
    assign bus.sbox_sel  = round_idx_q[0];
    assign bus.sbox_in_1 = sbox_in_1;
    assign bus.sbox_in_2 = sbox_in_2;
    assign bus.sbox_in_3 = sbox_in_3;

endmodule

// File: tb/tb_feistel_round_engine.sv
// ---------------------------------------------------------------------------
// tb_feistel_round_engine
//
// Purpose:
//   Self-checking bench for feistel_round_engine. A default-sized engine
//   (31 rounds) is driven with random blocks against random key and S-box
//   tables and compared with a word-level reference model; a second,
//   single-round engine with zero keys and an identity S-box checks a
//   fixed known answer. With FEISTEL_DECRYPT_EN defined the bench also
//   round-trips random blocks through decrypt; otherwise it checks that
//   mode=1 behaves exactly like encrypt.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_feistel_round_engine;

    localparam int W  = 9;
    localparam int NR = 31;
    localparam int RW = 8;

    logic clk;
    logic rst_n;

    int compared;
    int mismatched;

    // External key schedule (one key per lane per round) and two S-box tables.
    logic [W-1:0] key_tab  [3][256];
    logic [W-1:0] sbox_tab [2][512];

    feistel_round_engine_if #(.WORD_W(W), .RND_W(RW)) bus ();
    feistel_round_engine_if #(.WORD_W(W), .RND_W(RW)) bus1 ();

    feistel_round_engine #(.WORD_W(W), .NUM_ROUNDS(NR), .RND_W(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    feistel_round_engine #(.WORD_W(W), .NUM_ROUNDS(1), .RND_W(RW)) dut_one (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM-like environment for the main engine: keys by round, S-box by table.
    always_comb begin
        bus.key1       = key_tab[0][bus.round_idx];
        bus.key2       = key_tab[1][bus.round_idx];
        bus.key3       = key_tab[2][bus.round_idx];
        bus.sbox_out_1 = sbox_tab[bus.sbox_sel][bus.sbox_in_1];
        bus.sbox_out_2 = sbox_tab[bus.sbox_sel][bus.sbox_in_2];
        bus.sbox_out_3 = sbox_tab[bus.sbox_sel][bus.sbox_in_3];
    end

    // Single-round engine: all-zero keys and identity S-box.
    assign bus1.key1       = '0;
    assign bus1.key2       = '0;
    assign bus1.key3       = '0;
    assign bus1.sbox_out_1 = bus1.sbox_in_1;
    assign bus1.sbox_out_2 = bus1.sbox_in_2;
    assign bus1.sbox_out_3 = bus1.sbox_in_3;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4*W-1:0] rand_block();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[4*W-1:0];
    endfunction

    // Reference: NR forward rounds on an array of four words.
    function automatic logic [4*W-1:0] enc_ref(input logic [4*W-1:0] x);
        logic [W-1:0] w [4];
        logic [W-1:0] t1, t2, t3;
        int tb_sel;
        for (int k = 0; k < 4; k++) w[k] = x[k*W +: W];
        for (int r = 0; r < NR; r++) begin
            tb_sel = r % 2;
            t3 = key_tab[0][r] ^ w[2] ^ sbox_tab[tb_sel][w[3]];
            t2 = key_tab[1][r] ^ w[1] ^ sbox_tab[tb_sel][w[2]];
            t1 = key_tab[2][r] ^ w[0] ^ sbox_tab[tb_sel][w[1]];
            w[0] = w[3];
            w[3] = t3;
            w[2] = t2;
            w[1] = t1;
        end
        return {w[3], w[2], w[1], w[0]};
    endfunction

    // Starts a block at the current falling edge and follows it to done.
    // While running, busy and the round index sequence are checked each
    // cycle. At cycle glitch_cycle a start pulse with other data is injected.
    // Returns at the falling edge where done is seen (the DONE cycle).
    task automatic applyStimulus(input logic [4*W-1:0] din_v, input logic mode_v,
                                 input int glitch_cycle, input logic [4*W-1:0] glitch_din,
                                 output int lat, output logic [4*W-1:0] result);
        int c;
        int exp_i;
        int limit;
        bit dec_run;
`ifdef FEISTEL_DECRYPT_EN
        dec_run = mode_v;
`else
        dec_run = 1'b0;
`endif
        limit = 3 * NR + 10;
        lat = -1;
        result = '0;
        bus.start = 1'b1;
        bus.din   = din_v;
        bus.mode  = mode_v;
        @(negedge clk);
        bus.start = 1'b0;
        c = 1;
        while (c <= limit) begin
            if (bus.done === 1'b1) begin
                lat = c;
                result = bus.dout;
                break;
            end
            exp_i = dec_run ? (NR - 1) - (c - 1) / 3 : c - 1;
            checkOutput("busy_run", 64'(bus.busy), 64'(1));
            checkOutput("round_idx", 64'(bus.round_idx), 64'(exp_i));
            checkOutput("sbox_sel", 64'(bus.sbox_sel), 64'(exp_i & 1));
            if (c == glitch_cycle) begin
                bus.start = 1'b1;
                bus.din   = glitch_din;
                bus.mode  = ~mode_v;
            end else begin
                bus.start = 1'b0;
                bus.mode  = mode_v;
            end
            @(negedge clk);
            c++;
        end
        bus.start = 1'b0;
        if (lat < 0) checkOutput("done_timeout", 64'(bus.done), 64'(1));
    endtask

    initial begin
        int lat;
        int lat2;
        int c;
        int done_seen;
        logic [4*W-1:0] x;
        logic [4*W-1:0] y;
        logic [4*W-1:0] res;
        logic [4*W-1:0] res2;

        compared   = 0;
        mismatched = 0;
        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 256; i++) key_tab[k][i] = W'($urandom_range(511, 0));
        for (int t = 0; t < 2; t++)
            for (int i = 0; i < 512; i++) sbox_tab[t][i] = W'($urandom_range(511, 0));

        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.mode   = 1'b0;
        bus.din    = '0;
        bus1.start = 1'b0;
        bus1.mode  = 1'b0;
        bus1.din   = '0;
        repeat (3) @(negedge clk);

        $display("[TB] reset state");
        checkOutput("rst_dout", 64'(bus.dout), 64'(0));
        checkOutput("rst_busy", 64'(bus.busy), 64'(0));
        checkOutput("rst_done", 64'(bus.done), 64'(0));
        checkOutput("rst_round_idx", 64'(bus.round_idx), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] single-round known answer");
        bus1.start = 1'b1;
        bus1.din   = {9'h008, 9'h004, 9'h002, 9'h001} ;
        bus1.din   = {9'h001, 9'h002, 9'h004, 9'h008};
        @(negedge clk);
        bus1.start = 1'b0;
        checkOutput("one_busy_c1", 64'(bus1.busy), 64'(1));
        checkOutput("one_done_c1", 64'(bus1.done), 64'(0));
        @(negedge clk);
        checkOutput("one_done_c2", 64'(bus1.done), 64'(1));
        checkOutput("one_dout", 64'(bus1.dout), 64'({9'h003, 9'h006, 9'h00C, 9'h001}));
        @(negedge clk);
        checkOutput("one_done_pulse", 64'(bus1.done), 64'(0));

        $display("[TB] random encrypt blocks");
        repeat (4) begin
            x = rand_block();
            applyStimulus(x, 1'b0, 0, '0, lat, res);
            checkOutput("enc_latency", 64'(lat), 64'(NR + 1));
            checkOutput("enc_dout", 64'(res), 64'(enc_ref(x)));
            @(negedge clk);
            checkOutput("enc_done_pulse", 64'(bus.done), 64'(0));
            checkOutput("enc_dout_hold", 64'(bus.dout), 64'(enc_ref(x)));
        end

        $display("[TB] start while busy, then start in DONE cycle");
        x = rand_block();
        y = rand_block();
        applyStimulus(x, 1'b0, 5, rand_block(), lat, res);
        checkOutput("glitch_latency", 64'(lat), 64'(NR + 1));
        checkOutput("glitch_dout", 64'(res), 64'(enc_ref(x)));
        applyStimulus(y, 1'b0, 0, '0, lat2, res2);
        checkOutput("b2b_latency", 64'(lat2), 64'(NR + 1));
        checkOutput("b2b_dout", 64'(res2), 64'(enc_ref(y)));
        @(negedge clk);

        $display("[TB] reset during round 10");
        bus.din   = rand_block();
        bus.mode  = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        c = 0;
        while (bus.round_idx != 8'd10 && c < 50) begin
            @(negedge clk);
            c++;
        end
        checkOutput("reach_round10", 64'(bus.round_idx), 64'(10));
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_busy", 64'(bus.busy), 64'(0));
        checkOutput("midrst_done", 64'(bus.done), 64'(0));
        checkOutput("midrst_dout", 64'(bus.dout), 64'(0));
        checkOutput("midrst_round_idx", 64'(bus.round_idx), 64'(0));
        rst_n = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_seen++;
        end
        checkOutput("no_done_after_rst", 64'(done_seen), 64'(0));
        checkOutput("idle_after_rst", 64'(bus.busy), 64'(0));

`ifdef FEISTEL_DECRYPT_EN
        $display("[TB] encrypt/decrypt round trip");
        for (int n = 0; n < 100; n++) begin
            x = rand_block();
            applyStimulus(x, 1'b0, 0, '0, lat, res);
            checkOutput("rt_enc_latency", 64'(lat), 64'(NR + 1));
            checkOutput("rt_enc_dout", 64'(res), 64'(enc_ref(x)));
            @(negedge clk);
            applyStimulus(res, 1'b1, (n == 0) ? 7 : 0, rand_block(), lat2, res2);
            checkOutput("rt_dec_latency", 64'(lat2), 64'(3 * NR + 1));
            checkOutput("rt_dec_dout", 64'(res2), 64'(x));
            @(negedge clk);
        end
`else
        $display("[TB] mode=1 without decrypt support");
        repeat (3) begin
            x = rand_block();
            applyStimulus(x, 1'b1, 0, '0, lat, res);
            checkOutput("mode1_latency", 64'(lat), 64'(NR + 1));
            checkOutput("mode1_dout", 64'(res), 64'(enc_ref(x)));
            @(negedge clk);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
